// File: rtl/press_counter_7seg.sv
// Push-button press counter: a short press adds one to a two-digit BCD count,
// and a long press clears it. Both digits drive active-low seven-segment outputs.
module press_counter_7seg #(
    parameter int unsigned c_HOLD_LIMIT = 25000000,
    parameter int unsigned c_HOLD_WIDTH = 25
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch,
    output logic [3:0] o_Count_Tens,
    output logic [3:0] o_Count_Ones,
    output logic [6:0] o_Seg_Tens,
    output logic [6:0] o_Seg_Ones,
    output logic       o_Inc,
    output logic       o_Clear
);

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;
    localparam logic [c_HOLD_WIDTH-1:0] HOLD_MAX = c_HOLD_WIDTH'(c_HOLD_LIMIT - 1);
    localparam logic [SEG_W-1:0] SEG_ZERO = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t                  r_State;
    logic [c_HOLD_WIDTH-1:0] r_Hold;

    // Segment bit order is A..G from bit6 to bit0. A lit segment is 0. Non-BCD input blanks the digit.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] digit);
        case (digit)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Press classification FSM with BCD count and one-cycle event pulses
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State      <= WAIT_REL;
            r_Hold       <= '0;
            o_Count_Tens <= '0;
            o_Count_Ones <= '0;
            o_Inc        <= 1'b0;
            o_Clear      <= 1'b0;
        end else begin
            o_Inc   <= 1'b0;
            o_Clear <= 1'b0;
            case (r_State)
                IDLE: begin
                    if (i_Switch) begin
                        r_State <= PRESSED;
                        r_Hold  <= c_HOLD_WIDTH'(1);
                    end
                end
                PRESSED: begin
                    if (i_Switch) begin
                        if (r_Hold < HOLD_MAX) begin
                            r_Hold <= r_Hold + c_HOLD_WIDTH'(1);
                        end else begin
                            o_Count_Tens <= '0;
                            o_Count_Ones <= '0;
                            o_Clear      <= 1'b1;
                            r_State      <= WAIT_REL;
                        end
                    end else begin
                        // Short press is counted on release. 99 wraps to 00.
                        o_Inc   <= 1'b1;
                        r_State <= IDLE;
                        if (o_Count_Ones >= BCD_W'(9)) begin
                            o_Count_Ones <= '0;
                            o_Count_Tens <= (o_Count_Tens >= BCD_W'(9)) ? '0
                                            : o_Count_Tens + BCD_W'(1);
                        end else begin
                            o_Count_Ones <= o_Count_Ones + BCD_W'(1);
                        end
                    end
                end
                WAIT_REL: begin
                    if (!i_Switch) begin
                        r_State <= IDLE;
                    end
                end
                default: begin
                    r_State <= WAIT_REL;
                end
            endcase
        end
    end

    // The segment outputs are decoded from the count registers and lag them by one cycle.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Seg_Tens <= SEG_ZERO;
            o_Seg_Ones <= SEG_ZERO;
        end else begin
            o_Seg_Tens <= seg_decode(o_Count_Tens);
            o_Seg_Ones <= seg_decode(o_Count_Ones);
        end
    end

endmodule

// File: doc/press_counter_7seg.md
PRESS_COUNTER_7SEG -- requirements
Module: press_counter_7seg

Interface
REQ-001 Parameters SHALL be:
  - c_HOLD_LIMIT, default 25000000; consecutive high samples that make a long press (1 s at 25 MHz); legal range >= 2.
  - c_HOLD_WIDTH, default 25; hold-counter width, >= ceil(log2(c_HOLD_LIMIT)).
REQ-002 Ports SHALL be:
  - i_Clk  in  1  system clock, all logic on rising edge.
  - i_Rst  in  1  synchronous, active-high reset.
  - i_Switch  in  1  debounced switch level, 1 = pressed; assumed clean, not resynchronised here.
  - o_Count_Tens  out  4  BCD tens digit, 0..9.
  - o_Count_Ones  out  4  BCD ones digit, 0..9.
  - o_Seg_Tens  out  7  tens segments, active-low, bit6..bit0 = A..G.
  - o_Seg_Ones  out  7  ones segments, same encoding.
  - o_Inc  out  1  one-cycle pulse on count increment.
  - o_Clear  out  1  one-cycle pulse on long-press clear.
REQ-003 The block SHALL use one clock, and reset SHALL be synchronous and active-high (i_Rst sampled on i_Clk rising edge only).

Function
REQ-004 FSM SHALL have three states: IDLE, PRESSED and WAIT_REL.
REQ-005 IDLE transitions:
  - i_Switch=1: go to PRESSED, set r_Hold to 1.
  - i_Switch=0: stay in IDLE.
REQ-006 PRESSED with i_Switch=1:
  - r_Hold < c_HOLD_LIMIT-1: increment r_Hold, stay in PRESSED.
  - r_Hold == c_HOLD_LIMIT-1: BCD count to 00, o_Clear=1 for that cycle, go to WAIT_REL.
REQ-007 PRESSED with i_Switch=0 (short press, counted on release): increment the BCD count, o_Inc=1 for that cycle, go to IDLE.
REQ-008 Press classification SHALL be: exactly c_HOLD_LIMIT-1 consecutive high samples is short; c_HOLD_LIMIT samples is long.
REQ-009 WAIT_REL transitions: i_Switch=0 goes to IDLE; i_Switch=1 stays. No count change and no pulses in WAIT_REL.
REQ-010 BCD increment rules:
  - Ones 0..8: ones+1.
  - Ones 9: ones to 0, tens+1.
  - 99: wraps to 00, with o_Inc still asserted.
REQ-011 o_Count_Tens and o_Count_Ones SHALL update on the same edge that asserts o_Inc or o_Clear.
REQ-012 Segment outputs SHALL be registered from the BCD registers, lagging them by exactly 1 cycle.
REQ-013 Segment patterns (lit segments; lit = 0, unlit = 1):
  - 0 ABCDEF, 1 BC, 2 ABDEG, 3 ABCDG, 4 BCFG.
  - 5 ACDFG, 6 ACDEFG, 7 ABC, 8 ABCDEFG, 9 ABCDFG.
  - Example: digit 0 = 7'b0000001, digit 1 = 7'b1001111.
REQ-014 Any BCD value outside 0..9 SHALL drive all segments unlit (7'b1111111); unreachable in normal operation.
REQ-015 o_Inc and o_Clear SHALL never be high in the same cycle, and each SHALL be high for at most 1 consecutive cycle.
REQ-016 r_Hold SHALL not wrap; it saturates at c_HOLD_LIMIT-1 and is only meaningful in PRESSED.

Reset
REQ-017 With i_Rst=1 at an edge, the block SHALL set:
  - State WAIT_REL, r_Hold=0.
  - o_Count_Tens=0, o_Count_Ones=0.
  - o_Seg_Tens=o_Seg_Ones=7'b0000001.
  - o_Inc=0, o_Clear=0.
REQ-018 Reset SHALL take priority over all FSM activity, including a release or hold limit reached in the same cycle.
REQ-019 Resetting into WAIT_REL SHALL prevent a press held across reset from being counted or clearing; counting resumes only after a low sample.

Verification (c_HOLD_LIMIT=100, c_HOLD_WIDTH=7)
REQ-020 Reset with i_Switch=0, then 3 idle cycles:
  - Required: count 00, both segs 0000001, o_Inc=o_Clear=0.
  - FSM reaches IDLE after 1 cycle.
REQ-021 i_Switch high 10 cycles, then low:
  - o_Inc=1 exactly on the first low-sample edge.
  - o_Count_Ones=1 on that edge; o_Seg_Ones=1001111 one cycle later.
REQ-022 Boundary press lengths:
  - 99-cycle press: o_Inc, count +1.
  - 100-cycle press: o_Clear on the 100th high sample, count 00, no o_Inc on release.
REQ-023 Carry and wrap:
  - 9 short presses then 1 more: 09 -> 10, tens seg 1001111, ones seg 0000001.
  - From 99, one short press: 00, with o_Inc pulsed.
REQ-024 Reset mid-press:
  - Count 05, i_Switch high, i_Rst pulsed 1 cycle; hold i_Switch high 150 more cycles, then low.
  - Required: count 00 after reset, no o_Inc, no o_Clear.
  - A subsequent 5-cycle press gives count 01.
